// File: rtl/serial_subtractor8_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Default width, FSM encoding and bit-counter sizing.
package serial_subtractor8_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor8_fullsub1.sv
// One-bit full subtractor cell: x - y - bi.
// Purely combinational; the top steps it across the operand bits.
module fullsub1 (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Results are held from the done pulse until the next completed operation.
import serial_subtractor8_pkg::*;

module serial_subtractor8 #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             dbit;
  logic             bnext;
  logic [WIDTH-1:0] sh_next;

  fullsub1 u_fs (
    .x  (a_q[cnt_q]),
    .y  (b_q[cnt_q]),
    .bi (br_q),
    .d  (dbit),
    .bo (bnext)
  );

  assign sh_next = {dbit, sh_q[WIDTH-1:1]};

  // Next-state: accept operands when idle, step one bit per cycle in SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    sh_d    = sh_q;
    res_d   = res_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sh_d = sh_next;
        br_d = bnext;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          res_d   = sh_next;
          bout_d  = bnext;
          ovf_d   = (a_q[MSB] ^ b_q[MSB]) & (dbit ^ a_q[MSB]);
          zero_d  = (sh_next == '0);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      sh_q    <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign d    = res_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8.
// Vector table, corner sequences and a back-to-back random stream.
`timescale 1ns/1ps
module tb_serial_subtractor8;

  typedef struct {
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] d;
  logic       bout;
  logic       ovf;
  logic       zero;
  logic       busy;
  logic       done;

  int   n_cmp;
  int   n_err;
  int   done_cnt;
  exp_t q[$];
  exp_t e_mon;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x,
                                 input logic [7:0] y,
                                 input logic c);
    logic [8:0] r;
    exp_t  m;
    r      = {1'b0, x} - {1'b0, y} - {8'b0, c};
    m.d    = r[7:0];
    m.bout = r[8];
    m.ovf  = (x[7] != y[7]) && (r[7] != x[7]);
    m.zero = (r[7:0] == 8'h00);
    return m;
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got d=%0h expected no result", d);
      end else begin
        e_mon = q.pop_front();
        chk("d", 32'(d), 32'(e_mon.d));
        chk("bout", 32'(bout), 32'(e_mon.bout));
        chk("ovf", 32'(ovf), 32'(e_mon.ovf));
        chk("zero", 32'(zero), 32'(e_mon.zero));
      end
    end
  end

  task automatic wait_done(output int nb);
    bit seen;
    nb   = 0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) nb++;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 30");
    end
  endtask

  task automatic op(input logic [7:0] ia,
                    input logic [7:0] ib,
                    input logic ibin,
                    input exp_t ex);
    int nb;
    q.push_back(ex);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(nb);
    chk("busy_cycles", 32'(nb), 32'd8);
  endtask

  vec_t tbl[9];
  exp_t ex;
  int   dc0;
  int   nb;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    done_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    bin      = 1'b0;

    tbl[0] = '{8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h01, 8'h07, 1'b0, 8'hFA, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 8'h01, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h80, 8'hFF, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

    #12;
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_bout", 32'(bout), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_zero", 32'(zero), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      ex.d    = tbl[i].d;
      ex.bout = tbl[i].bout;
      ex.ovf  = tbl[i].ovf;
      ex.zero = tbl[i].zero;
      op(tbl[i].a, tbl[i].b, tbl[i].bin, ex);
    end

    // start during SHIFT is ignored
    @(posedge clk);
    #1;
    dc0     = done_cnt;
    ex.d    = 8'h0D;
    ex.bout = 1'b0;
    ex.ovf  = 1'b0;
    ex.zero = 1'b0;
    q.push_back(ex);
    a     = 8'h10;
    b     = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a     = 8'h55;
    b     = 8'h22;
    bin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_mid", 32'(busy), 32'h1);
    wait_done(nb);
    repeat (12) @(posedge clk);
    #1;
    chk("ignore_done_once", 32'(done_cnt - dc0), 32'd1);
    chk("ignore_idle", 32'(busy), 32'h0);

    // reset in the middle of SHIFT
    dc0   = done_cnt;
    a     = 8'h33;
    b     = 8'h11;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_d", 32'(d), 32'h0);
    chk("mid_rst_bout", 32'(bout), 32'h0);
    chk("mid_rst_ovf", 32'(ovf), 32'h0);
    chk("mid_rst_zero", 32'(zero), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("no_done_after_rst", 32'(done_cnt - dc0), 32'd0);
    chk("idle_after_rst", 32'(busy), 32'h0);
    ex.d    = 8'h0F;
    ex.bout = 1'b0;
    ex.ovf  = 1'b0;
    ex.zero = 1'b0;
    op(8'h10, 8'h01, 1'b0, ex);

    // start held high: one result every 9 cycles
    @(posedge clk);
    #1;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      bin = 1'($urandom_range(0, 1));
      q.push_back(model(a, b, bin));
      @(posedge clk);
      #1;
      if (i == 11) start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_done", 32'(done), 32'h1);
    end

    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request: capture operands and begin subtraction.
REQ-005 a  input  WIDTH  minuend.
REQ-006 b  input  WIDTH  subtrahend.
REQ-007 bin  input  1  borrow-in, subtracted at bit 0.
REQ-008 d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-009 bout  output  1  borrow-out from MSB; 1 means unsigned a < b + bin.
REQ-010 ovf  output  1  two's-complement overflow of the subtraction.
REQ-011 zero  output  1  d == 0.
REQ-012 busy  output  1  high while a subtraction is in progress.
REQ-013 done  output  1  one-cycle pulse when d, bout, ovf and zero become valid.

Function
REQ-014 The block SHALL have the states IDLE, SHIFT and DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and bin, clear the bit counter and enter SHIFT.
REQ-016 While in SHIFT or at reset, start SHALL be ignored; captured operands SHALL NOT change.
REQ-017 In SHIFT, each cycle SHALL process one bit, LSB first: diff = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br); br initialises to bin.
REQ-018 Each diff bit SHALL shift into the result register from the MSB side, so bit 0 reaches position 0 after WIDTH shifts.
REQ-019 SHIFT SHALL last exactly WIDTH cycles; the counter SHALL run 0..WIDTH-1 and SHALL NOT wrap.
REQ-020 busy SHALL be 1 in SHIFT only; for a start sampled at edge E0, busy SHALL be 1 from E0 to E0+WIDTH.
REQ-021 At edge E0+WIDTH the block SHALL enter DONE, update d, bout, ovf and zero, and assert done for exactly one cycle.
REQ-022 ovf SHALL equal (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]) using captured operands; bin SHALL NOT alter this rule.
REQ-023 d, bout, ovf and zero SHALL hold their values from DONE until the next completed operation; they SHALL NOT change during SHIFT.
REQ-024 A start accepted in the DONE cycle SHALL begin a new operation with no idle gap (back-to-back throughput of one result per WIDTH+1 cycles).
REQ-025 With no start, DONE SHALL return to IDLE after one cycle.
REQ-026 The result SHALL be bit-exact with a combinational a - b - bin for all 2^(2*WIDTH+1) inputs.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, counter 0, borrow register 0 and d=0, bout=0, ovf=0, zero=0, busy=0, done=0, independent of clk.
REQ-028 Reset during SHIFT SHALL abandon the operation; no done pulse SHALL follow release.
REQ-029 After rst_n rises, the first start SHALL be accepted at the first rising edge with rst_n=1.

Structure
REQ-030 A shared package SHALL hold the WIDTH default, the state encoding (IDLE, SHIFT, DONE) and the counter width ($clog2(WIDTH)).
REQ-031 The one-bit difference/borrow cell SHALL be a sub-module named fullsub1 (ports x, y, bi, d, bo); the top SHALL instantiate it once.
REQ-032 All sequential logic SHALL be in the top module; fullsub1 SHALL be purely combinational.

Verification
REQ-033 a=0x01, b=0x01, bin=0, start 1 cycle -> busy 8 cycles, done pulse, d=0x00, bout=0, ovf=0, zero=1.
REQ-034 a=0x01, b=0x07, bin=0 -> d=0xFA, bout=1, ovf=0, zero=0; then a=0x03, b=0x01, bin=1 -> d=0x01, bout=0.
REQ-035 a=0x80, b=0x7F -> d=0x01, bout=0, ovf=1; a=0x80, b=0xFF -> d=0x81, bout=1, ovf=0.
REQ-036 start pulsed again 3 cycles into SHIFT with different a/b -> ignored; result matches the first operands; done exactly once.
REQ-037 rst_n low 4 cycles into SHIFT -> all outputs 0 immediately, no done after release; next start with a=0x10, b=0x01 -> d=0x0F.
REQ-038 start held high continuously -> done every 9 cycles, results match a random stream checked against a combinational reference model.
